// File: rtl/syscall_drain_seq_pkg.sv
// Shared definitions for the syscall/LL-SC drain sequencer.
// Holds the FSM state encoding and the decoder ALU control codes that
// mark an instruction as LL or SC. The decoder uses the same codes.
// Ports: none (package).
package syscall_drain_seq_pkg;

  // Sequencer states; the encoding is visible to anything probing the FSM.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    SIGNAL  = 2'd2,
    RELEASE = 2'd3
  } drainState_e;

  localparam logic [5:0] LLSC_LL = 6'b101000;
  localparam logic [5:0] LLSC_SC = 6'b110110;

  // LL and SC serialize like a syscall but never raise SYS.
  function automatic logic isLlsc(input logic [5:0] aluCtrl);
    return (aluCtrl == LLSC_LL) || (aluCtrl == LLSC_SC);
  endfunction

endpackage

// File: rtl/syscall_drain_stats.sv
// Event counters for the drain sequencer, built only with SYSDRAIN_STATS_EN.
// Ports:
//   clk_i, rst_ni     clock and asynchronous active-low reset
//   start_i           one-cycle pulse on the IDLE->DRAIN transition
//   llsc_i            classification of the instruction starting the sequence
//   busy_i            sequencer is outside IDLE this cycle
//   syscalls_o        sequences started by a real syscall (wraps at 2^32)
//   llsc_o            sequences started by LL/SC (wraps at 2^32)
//   stall_o           cycles spent outside IDLE (wraps at 2^32)
module syscall_drain_stats (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        llsc_i,
  input  logic        busy_i,
  output logic [31:0] syscalls_o,
  output logic [31:0] llsc_o,
  output logic [31:0] stall_o
);

  logic [31:0] syscalls_q;
  logic [31:0] llsc_q;
  logic [31:0] stall_q;

  // Each sequence start lands in exactly one of the two start counters;
  // the stall counter simply accumulates busy cycles and wraps naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      syscalls_q <= '0;
      llsc_q     <= '0;
      stall_q    <= '0;
    end else begin
      if (start_i && !llsc_i) syscalls_q <= syscalls_q + 32'd1;
      if (start_i && llsc_i)  llsc_q     <= llsc_q + 32'd1;
      if (busy_i)             stall_q    <= stall_q + 32'd1;
    end
  end

  assign syscalls_o = syscalls_q;
  assign llsc_o     = llsc_q;
  assign stall_o    = stall_q;

endmodule

// File: rtl/syscall_drain_seq.sv
// Serializing sequencer for SYSCALL and LL/SC in the ID stage.
// When ID holds such an instruction, fetch is frozen and ID emits bubbles
// for DRAIN_CYCLES cycles so older instructions leave the pipe; then SYS
// pulses for one cycle (syscalls only) and the freeze is inhibited for one
// cycle so fetch steps past the instruction. Cache misses hold the sequence.
// Optional macro SYSDRAIN_STATS_EN adds the stat_* counter outputs.
// Ports:
//   CLK, RESET              clock, asynchronous active-low reset
//   syscall_IN              decoder flags a serializing instruction in ID
//   ALU_control_IN          decoder ALU control, used to recognise LL/SC
//   hit                     cache hit; low means a memory stall
//   WANT_FREEZE             fetch must hold its PC (combinational)
//   bubble_OUT              ID must emit a NOP (combinational)
//   SYS                     one-cycle syscall service request (registered)
//   inhibit_OUT             high while in RELEASE (registered)
//   sys_count               one-cycle delayed drain counter (registered)
//   Request_Alt_PC_mask     forces ID's Request_Alt_PC low (combinational)
//   stat_*_OUT              event counters (SYSDRAIN_STATS_EN only)
module syscall_drain_seq
  import syscall_drain_seq_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             syscall_IN,
  input  logic [5:0]       ALU_control_IN,
  input  logic             hit,
  output logic             WANT_FREEZE,
  output logic             bubble_OUT,
  output logic             SYS,
  output logic             inhibit_OUT,
  output logic [CNT_W-1:0] sys_count,
  output logic             Request_Alt_PC_mask
`ifdef SYSDRAIN_STATS_EN
  ,
  output logic [31:0]      stat_syscalls_OUT,
  output logic [31:0]      stat_llsc_OUT,
  output logic [31:0]      stat_stall_OUT
`endif
);

  drainState_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] sysCount_q;
  logic             llsc_q;
  logic             sys_q;
  logic             inhibit_q;

  logic startSeq;
  logic draining;

  assign startSeq = (state_q == IDLE) && syscall_IN;
  assign draining = (state_q == DRAIN) || (state_q == SIGNAL);

  // Sequencer FSM. A miss (hit low) holds IDLE, DRAIN and RELEASE in place,
  // but SIGNAL always advances so SYS can never stretch past one cycle.
  // sys_count trails cnt by one edge and is updated regardless of state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sysCount_q <= '0;
      llsc_q     <= 1'b0;
      sys_q      <= 1'b0;
      inhibit_q  <= 1'b0;
    end else begin
      sysCount_q <= cnt_q;
      case (state_q)
        IDLE: begin
          if (syscall_IN && hit) begin
            state_q <= DRAIN;
            cnt_q   <= CNT_W'(DRAIN_CYCLES);
            llsc_q  <= isLlsc(ALU_control_IN);
          end
        end
        DRAIN: begin
          if (hit) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= SIGNAL;
              sys_q   <= !llsc_q;
            end
          end
        end
        SIGNAL: begin
          state_q   <= RELEASE;
          sys_q     <= 1'b0;
          inhibit_q <= 1'b1;
        end
        RELEASE: begin
          if (hit) begin
            state_q   <= IDLE;
            inhibit_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RELEASE deliberately contributes no freeze so fetch can step past the
  // serialized instruction; only a miss freezes fetch there.
  assign WANT_FREEZE         = !hit || startSeq || draining;
  assign bubble_OUT          = startSeq || draining;
  assign Request_Alt_PC_mask = WANT_FREEZE;
  assign SYS                 = sys_q;
  assign inhibit_OUT         = inhibit_q;
  assign sys_count           = sysCount_q;

`ifdef SYSDRAIN_STATS_EN
  syscall_drain_stats u_stats (
    .clk_i      (CLK),
    .rst_ni     (RESET),
    .start_i    (startSeq && hit),
    .llsc_i     (isLlsc(ALU_control_IN)),
    .busy_i     (state_q != IDLE),
    .syscalls_o (stat_syscalls_OUT),
    .llsc_o     (stat_llsc_OUT),
    .stall_o    (stat_stall_OUT)
  );
`endif

endmodule

// File: doc/syscall_drain_seq.md
Name: syscall_drain_seq

Overview:
Sequencer that serializes SYSCALL and LL/SC instructions in the ID stage.
- On detecting one, it freezes fetch and makes ID emit bubbles until the older instructions have drained.
- It then pulses SYS to the simulator (SYSCALL only), inhibits the freeze for one cycle so fetch steps past the instruction, and returns to idle.
- It sits beside the ID stage, between the decoder outputs and the fetch freeze/alternate-PC logic. Cache misses (hit low) hold the sequence in place.

Parameters:
DRAIN_CYCLES, 3, number of bubble cycles before SYS is issued; legal range 1..7.
CNT_W, 3, width of the drain counter; must satisfy 2^CNT_W > DRAIN_CYCLES.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RESET  input  1  asynchronous, active-low reset.
syscall_IN  input  1  decoder flags the ID instruction as syscall/serializing (includes LL/SC).
ALU_control_IN  input  6  decoder ALU control of the ID instruction; used for LL/SC classification.
hit  input  1  cache hit; 0 = memory stall in progress.
WANT_FREEZE  output  1  combinational; fetch must hold its PC.
bubble_OUT  output  1  combinational; ID must emit a NOP (opcode 32'hc retained if the instruction is a syscall).
SYS  output  1  registered; one-cycle request to the simulator to service the syscall.
inhibit_OUT  output  1  registered; 1 during RELEASE.
sys_count  output  CNT_W  registered copy of the drain counter, for debug.
Request_Alt_PC_mask  output  1  combinational; 1 forces ID's registered Request_Alt_PC to 0.

Behaviour:
States: IDLE, DRAIN, SIGNAL, RELEASE. Registers: state, cnt, llsc_q, SYS, inhibit_OUT.

Reset (RESET=0, asynchronous):
- state=IDLE, cnt=0, llsc_q=0, SYS=0, inhibit_OUT=0, sys_count=0.
- Reset asserted mid-sequence aborts it; SYS must not fire afterwards.

llsc = (ALU_control_IN==LLSC_LL) or (ALU_control_IN==LLSC_SC).

Transitions:
- IDLE: if syscall_IN && hit: go to DRAIN, cnt<=DRAIN_CYCLES, llsc_q<=llsc. If hit=0, stay in IDLE (the miss freeze covers it).
- DRAIN: if hit: cnt<=cnt-1; if cnt==1, go to SIGNAL and SYS<=!llsc_q. If hit=0, hold state and cnt.
- SIGNAL: unconditionally go to RELEASE on the next edge, SYS<=0, inhibit_OUT<=1.
  - SYS is therefore high for exactly one cycle, even if hit falls during SIGNAL.
- RELEASE: if hit, go to IDLE and inhibit_OUT<=0. If hit=0, hold state and keep inhibit_OUT=1.
- syscall_IN is ignored outside IDLE. A second syscall in the cycle after RELEASE restarts the sequence from IDLE normally (back-to-back syscalls are supported).

Combinational outputs:
- WANT_FREEZE = !hit | (state==IDLE & syscall_IN) | (state==DRAIN) | (state==SIGNAL).
  - RELEASE never raises a freeze except through !hit.
- bubble_OUT = (state==IDLE & syscall_IN) | DRAIN | SIGNAL.
- Request_Alt_PC_mask = WANT_FREEZE.

sys_count <= cnt every edge (one-cycle delayed view).

Latency: syscall presented in cycle 0 with hit=1 throughout gives SYS high in cycle DRAIN_CYCLES+1 and IDLE again in cycle DRAIN_CYCLES+3.

Optional Feature:
Macro SYSDRAIN_STATS_EN.
- Defined: adds outputs stat_syscalls_OUT[31:0], stat_llsc_OUT[31:0] and stat_stall_OUT[31:0].
  - stat_syscalls_OUT / stat_llsc_OUT increment on the IDLE->DRAIN edge according to llsc.
  - stat_stall_OUT increments every cycle with state!=IDLE.
  - All three are 0 on reset and wrap modulo 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, DRAIN=2'd1, SIGNAL=2'd2, RELEASE=2'd3) and the ALU control codes LLSC_LL=6'b101000 and LLSC_SC=6'b110110. The decoder uses the same codes.
- One natural sub-module: syscall_drain_stats, holding the three counters, instantiated only under SYSDRAIN_STATS_EN. The FSM stays in the top module.

Test Plan:
- Basic syscall: DRAIN_CYCLES=3, hit=1, syscall_IN=1 with ALU_control_IN=0 in cycle 0 → WANT_FREEZE=1 in cycles 0-3; sys_count shows 3,2,1; SYS=1 only in cycle 4; inhibit_OUT=1 in cycle 5; IDLE in cycle 6.
- LL/SC: same stimulus with ALU_control_IN=6'b110110 → identical timing but SYS stays 0 throughout; stat_llsc_OUT=1 when SYSDRAIN_STATS_EN is defined.
- Miss during drain: hit=0 for 4 cycles starting in cycle 2 → cnt frozen at 2; SYS delayed to cycle 8; WANT_FREEZE high the whole time.
- Miss in SIGNAL/RELEASE: hit=0 from cycle 4 for 3 cycles → SYS high for exactly one cycle (cycle 4); RELEASE held until hit returns; inhibit_OUT stays 1 while held.
- Reset mid-sequence: RESET=0 while in DRAIN with cnt=2 → all outputs 0 immediately (asynchronous); SYS never pulses after reset is released.
- Back-to-back: second syscall presented the cycle after IDLE is re-entered → a second complete sequence; stat_syscalls_OUT=2.
